// File: rtl/gray_stream_src_if.sv
// Pixel handshake between the frame-buffer read FIFO (master) and gray_stream_src (slave).
interface gray_stream_src_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/gray_stream_src.sv
// Raster video source: RGB565 FIFO pixels -> 8-bit gray with de/vs timing, 2-cycle datapath latency.
// Optional macro GRAY_CONV_EN: full luminance; when undefined, o_data is the expanded green channel.
module gray_stream_src #(
    parameter int COL_NUM = 320,
    parameter int ROW_NUM = 720,
    parameter int H_BLANK = 40,
    parameter int VS_LEN  = 4,
    parameter int V_BP    = 20
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic               en,
    gray_stream_src_if.slave   pix,
    output logic [7:0]         o_data,
    output logic               o_de,
    output logic               o_vs,
    output logic               frame_done,
    output logic               underflow
);
    typedef enum logic [2:0] {IDLE, VS, VBP, ACTIVE, HBLANK} state_t;

    localparam logic [15:0] COL_LAST = 16'(COL_NUM - 1);
    localparam logic [15:0] ROW_LAST = 16'(ROW_NUM - 1);
    localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
    localparam logic [15:0] VS_LAST  = 16'(VS_LEN - 1);
    localparam logic [15:0] VBP_LAST = 16'(V_BP - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt, col_cnt, col_nxt, row_cnt, row_nxt;
    logic        slot, frame_end;
    logic [1:0]  de_pipe, vs_pipe, done_pipe;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        col_nxt   = col_cnt;
        row_nxt   = row_cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) state_nxt = VS;
            end
            VS: begin
                if (cnt == VS_LAST) begin
                    state_nxt = VBP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            VBP: begin
                if (cnt == VBP_LAST) begin
                    state_nxt = ACTIVE;
                    cnt_nxt   = '0;
                    col_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ACTIVE: begin
                if (col_cnt == COL_LAST) begin
                    state_nxt = HBLANK;
                    col_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    col_nxt = col_cnt + 16'd1;
                end
            end
            HBLANK: begin
                if (cnt == HB_LAST) begin
                    cnt_nxt = '0;
                    if (row_cnt < ROW_LAST) begin
                        state_nxt = ACTIVE;
                        row_nxt   = row_cnt + 16'd1;
                    end else begin
                        state_nxt = IDLE;
                        row_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every ACTIVE cycle is a slot regardless of pix_valid so raster timing never stalls.
    assign slot          = (state == ACTIVE);
    assign pix.pix_ready = slot;
    // First HBLANK cycle of the last row; two pipeline stages later it lands right after the final o_de.
    assign frame_end     = (state == HBLANK) && (cnt == '0) && (row_cnt == ROW_LAST);

    always_ff @(posedge sclk) begin
        if (rst) begin
            de_pipe   <= '0;
            vs_pipe   <= '0;
            done_pipe <= '0;
            underflow <= 1'b0;
        end else begin
            de_pipe   <= {de_pipe[0], slot};
            vs_pipe   <= {vs_pipe[0], state == VS};
            done_pipe <= {done_pipe[0], frame_end};
            if (slot && !pix.pix_valid) underflow <= 1'b1;
        end
    end

    assign o_de       = de_pipe[1];
    assign o_vs       = vs_pipe[1];
    assign frame_done = done_pipe[1];

`ifdef GRAY_CONV_EN
    logic [15:0] pix_in;
    logic [7:0]  r8, g8, b8;
    logic [15:0] prod_r, prod_g, prod_b;

    assign pix_in = (slot && pix.pix_valid) ? pix.pix_data : '0;
    assign r8 = {pix_in[15:11], pix_in[15:13]};
    assign g8 = {pix_in[10:5],  pix_in[10:9]};
    assign b8 = {pix_in[4:0],   pix_in[4:2]};

    always_ff @(posedge sclk) begin
        if (rst) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            o_data <= '0;
        end else begin
            prod_r <= 16'(r8) * 16'd77;
            prod_g <= 16'(g8) * 16'd150;
            prod_b <= 16'(b8) * 16'd29;
            // Weights sum to 256, so the 16-bit sum cannot overflow.
            o_data <= 8'((prod_r + prod_g + prod_b) >> 8);
        end
    end
`else
    logic [5:0] g_in;
    logic [7:0] g_s1;

    assign g_in = (slot && pix.pix_valid) ? pix.pix_data[10:5] : '0;

    always_ff @(posedge sclk) begin
        if (rst) begin
            g_s1   <= '0;
            o_data <= '0;
        end else begin
            g_s1   <= {g_in, g_in[5:4]};
            o_data <= g_s1;
        end
    end
`endif
endmodule

// File: tb/tb_gray_stream_src.sv
// Directed-vector bench for gray_stream_src with a 4x2 raster and short blanking.
module tb_gray_stream_src;
    typedef struct {
        logic [15:0] pix;
        bit          valid;
        logic [7:0]  exp;
    } vec_t;

    logic       sclk = 1'b0;
    logic       rst, en;
    logic [7:0] o_data;
    logic       o_de, o_vs, frame_done, underflow;

    gray_stream_src_if pif();

    gray_stream_src #(.COL_NUM(4), .ROW_NUM(2), .H_BLANK(2), .VS_LEN(2), .V_BP(3)) dut (
        .sclk(sclk), .rst(rst), .en(en), .pix(pif.slave),
        .o_data(o_data), .o_de(o_de), .o_vs(o_vs),
        .frame_done(frame_done), .underflow(underflow)
    );

    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    vec_t va[8];
    vec_t vb[8];
    vec_t src[$];
    int slot_cyc[$], de_cyc[$], vs_cyc[$], done_cyc[$];
    logic [7:0] de_dat[$];

    task automatic tick();
        @(posedge sclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs ncyc cycles with en high for the first en_cycles; asserts rst on slot rst_slot and returns after it.
    task automatic run(input int ncyc, input int en_cycles, input int rst_slot);
        int slot = 0;
        slot_cyc.delete(); de_cyc.delete(); vs_cyc.delete(); done_cyc.delete(); de_dat.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (o_de) begin de_cyc.push_back(cyc); de_dat.push_back(o_data); end
            if (o_vs) vs_cyc.push_back(cyc);
            if (frame_done) done_cyc.push_back(cyc);
            en = (c < en_cycles);
            rst = 1'b0;
            pif.pix_data = '0;
            pif.pix_valid = 1'b0;
            if (pif.pix_ready) begin
                if (slot == rst_slot) rst = 1'b1;
                pif.pix_data  = (slot < src.size()) ? src[slot].pix : 16'hFFFF;
                pif.pix_valid = (slot < src.size()) ? src[slot].valid : 1'b1;
                slot_cyc.push_back(cyc);
                slot++;
            end
            tick();
            if (rst) begin
                chk("rst_clears_de", int'(o_de), 0);
                chk("rst_clears_vs", int'(o_vs), 0);
                rst = 1'b0;
                return;
            end
        end
        pif.pix_valid = 1'b0;
    endtask

    function automatic int de_at(input int i);
        return (i < de_dat.size()) ? int'(de_dat[i]) : -1;
    endfunction

    initial begin
        int bad;
`ifdef GRAY_CONV_EN
        va[0] = '{16'hFFFF, 1'b1, 8'd255};
        va[1] = '{16'h0000, 1'b1, 8'd0};
        va[2] = '{16'hF800, 1'b1, 8'd76};
        va[3] = '{16'h07E0, 1'b1, 8'd149};
        va[4] = '{16'h001F, 1'b1, 8'd28};
        va[5] = '{16'hF81F, 1'b1, 8'd105};
        va[6] = '{16'h8410, 1'b1, 8'd130};
        va[7] = '{16'h0841, 1'b1, 8'd8};
`else
        va[0] = '{16'hFFFF, 1'b1, 8'd255};
        va[1] = '{16'h0000, 1'b1, 8'd0};
        va[2] = '{16'hF800, 1'b1, 8'd0};
        va[3] = '{16'h07E0, 1'b1, 8'd255};
        va[4] = '{16'h001F, 1'b1, 8'd0};
        va[5] = '{16'hF81F, 1'b1, 8'd0};
        va[6] = '{16'h8410, 1'b1, 8'd130};
        va[7] = '{16'h0841, 1'b1, 8'd8};
`endif
        for (int i = 0; i < 8; i++) vb[i] = '{16'hFFFF, 1'b1, 8'd255};
        vb[2] = '{16'hFFFF, 1'b0, 8'd0};

        rst = 1'b1; en = 1'b0; pif.pix_data = '0; pif.pix_valid = 1'b0;
        repeat (3) tick();
        chk("reset_o_data", int'(o_data), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pif.pix_ready || o_de || o_vs || underflow) bad++;
        end
        chk("idle_50_quiet_cycles", bad, 0);

        // Frame A: en dropped during row 0, one full frame of colour vectors.
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(va[i]);
        run(30, 8, -1);
        for (int i = 0; i < 8; i++) chk($sformatf("A_pix%0d", i), de_at(i), int'(va[i].exp));
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (i >= de_cyc.size() || i >= slot_cyc.size() || de_cyc[i] - slot_cyc[i] != 2) bad++;
        chk("A_latency_errs", bad, 0);
        chk("A_de_count", de_cyc.size(), 8);
        bad = 0;
        for (int i = 1; i < de_cyc.size(); i++)
            if (de_cyc[i] - de_cyc[i-1] != ((i == 4) ? 3 : 1)) bad++;
        chk("A_de_spacing_errs", bad, 0);
        chk("A_vs_cycles", vs_cyc.size(), 2);
        chk("A_vs_contig", (vs_cyc.size() == 2) ? vs_cyc[1] - vs_cyc[0] : -1, 1);
        chk("A_done_pulses", done_cyc.size(), 1);
        chk("A_done_after_last_de",
            (done_cyc.size() > 0 && de_cyc.size() == 8) ? done_cyc[0] - de_cyc[7] : -1, 1);
        chk("A_underflow", int'(underflow), 0);

        // Frame B: third slot of row 0 starved.
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(vb[i]);
        run(30, 8, -1);
        for (int i = 0; i < 8; i++) chk($sformatf("B_pix%0d", i), de_at(i), int'(vb[i].exp));
        chk("B_de_count", de_cyc.size(), 8);
        chk("B_row_split", (de_cyc.size() == 8) ? de_cyc[4] - de_cyc[3] : -1, 3);
        chk("B_underflow_set", int'(underflow), 1);
        repeat (10) tick();
        chk("B_underflow_sticky", int'(underflow), 1);

        // Frame C: en held through a frame boundary -> back-to-back frames, 1-cycle IDLE.
        src.delete();
        run(45, 20, -1);
        chk("C_de_count", de_cyc.size(), 16);
        chk("C_vs_cycles", vs_cyc.size(), 4);
        chk("C_frame_period", (vs_cyc.size() >= 3) ? vs_cyc[2] - vs_cyc[0] : -1, 18);
        chk("C_done_pulses", done_cyc.size(), 2);

        // Frame D: rst at row 1 col 2, then nothing more.
        run(40, 40, 6);
        run(20, 0, -1);
        chk("D_no_de_after_rst", de_cyc.size(), 0);
        chk("D_no_vs_after_rst", vs_cyc.size(), 0);
        chk("D_underflow_cleared", int'(underflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
